imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a program as a byte

---
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a length-prefixed little-endian byte stream into
// 32-bit words, writes them to instruction memory and raises cpu_start_o when done.
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        restart_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic [15:0] words_done_o,
  output logic        cpu_start_o,
  output logic        error_o
);

  localparam logic [2:0] S_HDR0  = 3'd0;
  localparam logic [2:0] S_HDR1  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [15:0] words_done_q, words_done_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        xfer;
  logic [15:0] hdr_n;

  assign byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign xfer         = byte_valid_i && byte_ready_o;
  assign hdr_n        = {byte_data_i, n_q[7:0]};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
    state_d      = state_q;
    n_d          = n_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    words_done_d = words_done_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = byte_data_i;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0)                state_d = S_DONE;
          else if ({1'b0, hdr_n} > DEPTH_W)  state_d = S_ERROR;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Last lane goes straight into the write register; word_q holds the lower three.
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, words_done_q, 2'b00};
            wdata_d = {byte_data_i, word_q[23:0]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_done_d = words_done_q + 16'd1;
        state_d      = (words_done_d == n_q) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERROR: begin
        if (restart_i) begin
          state_d      = S_HDR0;
          n_d          = 16'd0;
          byte_cnt_d   = 2'd0;
          words_done_d = 16'd0;
        end
      end
      default: state_d = S_HDR0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_HDR0;
      n_q          <= 16'd0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      words_done_q <= 16'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      words_done_q <= words_done_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign words_done_o = words_done_q;
  assign cpu_start_o  = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (DEPTH 256 and 4) share one directed stream and are
// compared every cycle against a transfer-level model, plus literal expectations per scenario.
module tb_imem_loader;

  localparam int unsigned DEPTH_A = 256;
  localparam int unsigned DEPTH_B = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        restart_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;

  logic        ready_a, we_a, start_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic [15:0] wd_a;
  logic        ready_b, we_b, start_b, err_b;
  logic [31:0] addr_b, wdata_b;
  logic [15:0] wd_b;

  imem_loader #(.DEPTH(DEPTH_A), .BASE_ADDR(32'h0)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .restart_i(restart_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(ready_a),
    .imem_we_o(we_a), .imem_addr_o(addr_a), .imem_wdata_o(wdata_a),
    .words_done_o(wd_a), .cpu_start_o(start_a), .error_o(err_a)
  );

  imem_loader #(.DEPTH(DEPTH_B), .BASE_ADDR(32'h0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .restart_i(restart_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(ready_b),
    .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_wdata_o(wdata_b),
    .words_done_o(wd_b), .cpu_start_o(start_b), .error_o(err_b)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model. Every header count used below is either <= 4 or > 256, so both
  // instances must behave identically and share this one model.
  int          m_hdr = 0;
  int          m_n = 0;
  int          m_written = 0;
  bit          m_pend = 1'b0;
  bit          m_loaded = 1'b0;
  bit          m_err = 1'b0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;

  function automatic bit m_ready();
    return (m_hdr < 2) || (!m_pend && !m_loaded && !m_err);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_hdr = 0; m_n = 0; m_written = 0;
      m_pend = 1'b0; m_loaded = 1'b0; m_err = 1'b0;
      m_bytes.delete();
      m_addr = 32'h0; m_wdata = 32'h0;
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_written++;
      if (m_written == m_n) m_loaded = 1'b1;
    end else if (m_loaded || m_err) begin
      if (restart_i) begin
        m_hdr = 0; m_n = 0; m_written = 0;
        m_loaded = 1'b0; m_err = 1'b0;
        m_bytes.delete();
      end
    end else if (byte_valid_i && m_ready()) begin
      if (m_hdr == 0) begin
        m_n = int'(byte_data_i);
        m_hdr = 1;
      end else if (m_hdr == 1) begin
        m_n = m_n + 256 * int'(byte_data_i);
        m_hdr = 2;
        if (m_n == 0) m_loaded = 1'b1;
        else if (m_n > int'(DEPTH_A)) m_err = 1'b1;
      end else begin
        m_bytes.push_back(byte_data_i);
        if (m_bytes.size() == 4) begin
          m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_addr  = 32'(m_written * 4);
          m_pend  = 1'b1;
          m_bytes.delete();
        end
      end
    end
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk_i) begin
    check("a_ready", 32'(ready_a), 32'(m_ready()));
    check("a_we",    32'(we_a),    32'(m_pend));
    check("a_addr",  addr_a,       m_addr);
    check("a_wdata", wdata_a,      m_wdata);
    check("a_words", 32'(wd_a),    32'(m_written));
    check("a_start", 32'(start_a), 32'(m_loaded));
    check("a_error", 32'(err_a),   32'(m_err));
    check("b_ready", 32'(ready_b), 32'(m_ready()));
    check("b_we",    32'(we_b),    32'(m_pend));
    check("b_addr",  addr_b,       m_addr);
    check("b_wdata", wdata_b,      m_wdata);
    check("b_words", 32'(wd_b),    32'(m_written));
    check("b_start", 32'(start_b), 32'(m_loaded));
    check("b_error", 32'(err_b),   32'(m_err));
    if (we_a) begin
      log_addr.push_back(addr_a);
      log_data.push_back(wdata_a);
    end
  end

  // Holds valid until the loader takes the byte; gap adds one idle cycle afterwards.
  task automatic send_byte(input logic [7:0] d, input bit gap);
    bit taken = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge clk_i);
      taken = ready_a;
    end
    if (!taken) check("byte_ready_wait", 32'(ready_a), 32'd1);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40 && !start_a; i++) @(negedge clk_i);
    check(name, 32'(start_a), 32'd1);
  endtask

  task automatic pulse_restart();
    @(posedge clk_i); #1;
    restart_i = 1'b1;
    @(posedge clk_i); #1;
    restart_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_we",    32'(we_a),    32'd0);
    check("rst_addr",  addr_a,       32'd0);
    check("rst_wdata", wdata_a,      32'd0);
    check("rst_words", 32'(wd_a),    32'd0);
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_error", 32'(err_a),   32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 1: single word, valid every cycle
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
    wait_start("t1_start");
    check("t1_nwrites", log_addr.size(), 32'd1);
    check("t1_addr",    log_addr[0],     32'h0);
    check("t1_wdata",   log_data[0],     32'h00A00513);
    check("t1_words",   32'(wd_a),       32'd1);

    // 2: three words with valid toggling; a restart mid-load must be ignored
    pulse_restart();
    log_addr.delete(); log_data.delete();
    send_byte(8'h03, 1); send_byte(8'h00, 1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1);
    pulse_restart();
    check("t2_start_early", 32'(start_a), 32'd0);
    check("t2_words_mid",   32'(wd_a),    32'd2);
    for (int i = 8; i < 12; i++) send_byte(8'(8'h10 + i), 1);
    wait_start("t2_start");
    check("t2_nwrites", log_addr.size(), 32'd3);
    if (log_addr.size() == 3) begin
      check("t2_addr0",  log_addr[0], 32'h0);
      check("t2_addr1",  log_addr[1], 32'h4);
      check("t2_addr2",  log_addr[2], 32'h8);
      check("t2_wdata0", log_data[0], 32'h13121110);
      check("t2_wdata1", log_data[1], 32'h17161514);
      check("t2_wdata2", log_data[2], 32'h1B1A1918);
    end

    // 3: empty program
    pulse_restart();
    log_addr.delete(); log_data.delete();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("t3_start",   32'(start_a),    32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    check("t3_nwrites", log_addr.size(), 32'd0);

    // 4: header count 257 exceeds DEPTH
    pulse_restart();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    check("t4_error", 32'(err_a),   32'd1);
    check("t4_ready", 32'(ready_a), 32'd0);
    byte_valid_i = 1'b1; byte_data_i = 8'h55;
    repeat (3) @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
    check("t4_nwrites", log_addr.size(), 32'd0);
    pulse_restart();
    check("t4_error_clr", 32'(err_a),   32'd0);
    check("t4_ready_hdr", 32'(ready_a), 32'd1);

    // 5: asynchronous reset after two data bytes, then a clean reload
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #3;
    rst_i = 1'b1;
    #1;
    check("t5_we",    32'(we_a),    32'd0);
    check("t5_words", 32'(wd_a),    32'd0);
    check("t5_start", 32'(start_a), 32'd0);
    check("t5_error", 32'(err_a),   32'd0);
    check("t5_addr",  addr_a,       32'd0);
    check("t5_wdata", wdata_a,      32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    log_addr.delete(); log_data.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    wait_start("t5_start_reload");
    check("t5_nwrites", log_addr.size(), 32'd1);
    check("t5_wdata_reload", log_data[0], 32'hDEADBEEF);

    // 6: full load at N == 4 (the DEPTH of dut_b), then restart and reload one word
    pulse_restart();
    log_addr.delete(); log_data.delete();
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 0);
    wait_start("t6_start");
    check("t6_b_start", 32'(start_b),    32'd1);
    check("t6_b_error", 32'(err_b),      32'd0);
    check("t6_nwrites", log_addr.size(), 32'd4);
    if (log_addr.size() == 4) begin
      check("t6_last_addr",  log_addr[3], 32'h0C);
      check("t6_last_wdata", log_data[3], 32'h2F2E2D2C);
    end
    check("t6_words", 32'(wd_a), 32'd4);
    pulse_restart();
    check("t6_words_clr", 32'(wd_a), 32'd0);
    log_addr.delete(); log_data.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    wait_start("t6_start_reload");
    check("t6_nwrites_reload", log_addr.size(), 32'd1);
    check("t6_addr_reload",    log_addr[0],     32'h0);
    check("t6_wdata_reload",   log_data[0],     32'h12345678);

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
